imm_encoder: RTL and testbench

- Inverse of the pipeline's immediate decode path: packs decoded fields and a 32-bit signed immediate into a 32-bit RV instruction word.
- Sits between the test or boot loader and instruction memory. Each encoded word is emitted with its target byte address through a valid/ready register slice.
- Checks that the immediate is representable. A word that fails the check is replaced by a NOP and flagged.

---
 rtl/imm_encoder.sv | 145 ++++++++++++++
 tb/tb_imm_encoder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// Packs decoded RV32 fields and a signed immediate into an instruction word and
// streams it out with its target byte address through a one-entry register slice.
module imm_encoder #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [7:0]        err_count,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(BASE_ADDR + 4 * (DEPTH - 1));
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_instr_q, out_instr_d;
    logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
    logic              out_err_q,   out_err_d;
    logic [7:0]        err_count_q, err_count_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;

    logic [31:0] enc_instr;
    logic        enc_ok;
    logic        imm12_fits;
    logic        imm13_fits;
    logic        accept;
    logic [ADDR_W-1:0] word_addr;
    logic [7:0]  err_base;

    // Valid/ready: a transfer happens on any edge where valid && ready; the
    // producer holds its payload stable while valid is high and ready is low.
    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_addr  = out_addr_q;
    assign out_err   = out_err_q;
    assign err_count = err_count_q;
    assign busy      = out_valid_q;

    // Representable when every bit above the field's sign bit copies it.
    assign imm12_fits = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
    assign imm13_fits = (in_imm[31:12] == '0) || (in_imm[31:12] == '1);

    always_comb begin
        enc_instr = NOP;
        enc_ok    = 1'b0;
        unique case (in_opcode)
            OP_LOAD, OP_IALU: begin
                enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                enc_ok    = imm12_fits;
            end
            OP_STORE: begin
                enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                enc_ok    = imm12_fits;
            end
            OP_BRANCH: begin
                enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                             in_imm[4:1], in_imm[11], in_opcode};
                enc_ok    = imm13_fits && !in_imm[0];
            end
            OP_RTYPE: begin
                enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
                enc_ok    = 1'b1;
            end
            default: begin
                enc_instr = NOP;
                enc_ok    = 1'b0;
            end
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_addr_d  = out_addr_q;
        out_err_d   = out_err_q;
        addr_d      = addr_q;
        word_addr   = start ? BASE : addr_q;
        err_base    = start ? 8'd0 : err_count_q;
        err_count_d = err_base;

        if (start) begin
            addr_d = BASE;
        end

        if (accept) begin
            out_valid_d = 1'b1;
            out_instr_d = enc_ok ? enc_instr : NOP;
            out_err_d   = !enc_ok;
            out_addr_d  = word_addr;
            addr_d      = (word_addr == LAST) ? BASE : word_addr + STEP;
            if (!enc_ok && err_base != 8'hFF) begin
                err_count_d = err_base + 8'd1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_addr_q  <= '0;
            out_err_q   <= 1'b0;
            err_count_q <= '0;
            addr_q      <= BASE;
        end else begin
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_addr_q  <= out_addr_d;
            out_err_q   <= out_err_d;
            err_count_q <= err_count_d;
            addr_q      <= addr_d;
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed encodings, errors, backpressure, wrap/start,
// async reset, then random traffic checked through an expected-output queue.
module tb_imm_encoder;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        in_opcode;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;
    logic [7:0]        err_count;
    logic              busy;

    imm_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(0), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err),
        .err_count(err_count), .busy(busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard: {err, addr, instr}
    logic [31+ADDR_W+1:0] exp_q[$];
    logic [ADDR_W-1:0]    addr_m;
    logic [7:0]           err_m;
    int                   n_vec;
    int                   n_bad;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference encoder built from the field-placement tables.
    function automatic logic [31:0] model_enc(input logic [6:0] op, input logic [4:0] rd,
                                              input logic [4:0] rs1, input logic [4:0] rs2,
                                              input logic [2:0] f3, input logic [6:0] f7,
                                              input logic [31:0] imm);
        logic [31:0] w;
        w = 32'd0;
        w[6:0]   = op;
        w[14:12] = f3;
        w[19:15] = rs1;
        case (op)
            7'b0000011, 7'b0010011: begin
                w[11:7] = rd; w[31:20] = imm[11:0];
            end
            7'b0100011: begin
                w[24:20] = rs2; w[31:25] = imm[11:5]; w[11:7] = imm[4:0];
            end
            7'b1100011: begin
                w[24:20] = rs2; w[31] = imm[12]; w[30:25] = imm[10:5];
                w[11:8] = imm[4:1]; w[7] = imm[11];
            end
            7'b0110011: begin
                w[11:7] = rd; w[24:20] = rs2; w[31:25] = f7;
            end
            default: w = NOP;
        endcase
        return w;
    endfunction

    function automatic logic model_bad(input logic [6:0] op, input logic [31:0] imm);
        int s;
        s = $signed(imm);
        case (op)
            7'b0000011, 7'b0010011, 7'b0100011: return !(s >= -2048 && s <= 2047);
            7'b1100011: return !(s >= -4096 && s <= 4095 && imm[0] == 1'b0);
            7'b0110011: return 1'b0;
            default:    return 1'b1;
        endcase
    endfunction

    // One cycle: check registered outputs, drive inputs, score the coming edge.
    task automatic step(input logic v, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm, input logic ordy,
                        input logic st, input logic [31:0] exp_instr, input logic exp_err);
        logic full;
        logic acc;
        logic [31+ADDR_W+1:0] e;
        @(negedge clk);
        full = (exp_q.size() != 0);
        check("out_valid", {63'd0, out_valid}, {63'd0, full});
        check("busy", {63'd0, busy}, {63'd0, full});
        check("err_count", {56'd0, err_count}, {56'd0, err_m});
        if (full && out_valid) begin
            e = exp_q[0];
            check("out_instr", {32'd0, out_instr}, {32'd0, e[31:0]});
            check("out_addr", {{(64-ADDR_W){1'b0}}, out_addr}, {{(64-ADDR_W){1'b0}}, e[31+ADDR_W:32]});
            check("out_err", {63'd0, out_err}, {63'd0, e[32+ADDR_W]});
        end
        in_valid = v; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm; out_ready = ordy; start = st;
        #1;
        check("in_ready", {63'd0, in_ready}, {63'd0, (!full || ordy)});
        acc = v && (!full || ordy);
        if (full && ordy) void'(exp_q.pop_front());
        if (st) begin
            addr_m = '0;
            err_m  = 8'd0;
        end
        if (acc) begin
            exp_q.push_back({exp_err, addr_m, exp_instr});
            addr_m = (addr_m == ADDR_W'(4 * (DEPTH - 1))) ? '0 : addr_m + ADDR_W'(4);
            if (exp_err && err_m != 8'hFF) err_m = err_m + 8'd1;
        end
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, ordy, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic send_rand(input logic ordy, input logic st);
        logic [6:0] op;
        logic [31:0] imm;
        logic [4:0] rd, rs1, rs2;
        logic [2:0] f3;
        logic [6:0] f7;
        case ($urandom_range(0, 5))
            0: op = 7'b0000011;
            1: op = 7'b0010011;
            2: op = 7'b0100011;
            3: op = 7'b1100011;
            4: op = 7'b0110011;
            default: op = 7'($urandom_range(0, 127));
        endcase
        case ($urandom_range(0, 5))
            0: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
            1: imm = 32'd2047;
            2: imm = 32'hFFFF_F000;
            3: imm = 32'd4094;
            4: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            default: imm = $urandom;
        endcase
        rd  = 5'($urandom_range(0, 31));
        rs1 = 5'($urandom_range(0, 31));
        rs2 = 5'($urandom_range(0, 31));
        f3  = 3'($urandom_range(0, 7));
        f7  = 7'($urandom_range(0, 127));
        step(1'b1, op, rd, rs1, rs2, f3, f7, imm, ordy, st,
             model_bad(op, imm) ? NOP : model_enc(op, rd, rs1, rs2, f3, f7, imm),
             model_bad(op, imm));
    endtask

    initial begin
        n_vec = 0; n_bad = 0; addr_m = '0; err_m = 8'd0;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7 = '0; in_imm = '0;
        #1;
        check("rst_out_instr", {32'd0, out_instr}, 64'd0);
        check("rst_out_addr", {{(64-ADDR_W){1'b0}}, out_addr}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(1'b1);

        // addi x1,x0,-1
        step(1'b1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1'b1, 1'b0,
             32'hFFF0_0093, 1'b0);
        idle(1'b1);
        // sd x2,8(x3) with start, then beq x1,x2,-4 back-to-back
        step(1'b1, 7'b0100011, 5'd0, 5'd3, 5'd2, 3'd3, 7'd0, 32'd8, 1'b1, 1'b1,
             32'h0021_B423, 1'b0);
        step(1'b1, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC, 1'b1, 1'b0,
             32'hFE20_8EE3, 1'b0);
        idle(1'b1);

        // rejected words
        step(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b1, 1'b1, 32'd0, 1'b0);
        step(1'b1, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 1'b1, 1'b0, NOP, 1'b1);
        step(1'b1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b1, 1'b0, NOP, 1'b1);
        step(1'b1, 7'b1111111, 5'd1, 5'd2, 5'd3, 3'd1, 7'd0, 32'd0, 1'b1, 1'b0, NOP, 1'b1);
        idle(1'b1);
        check("err_count_3", {56'd0, err_count}, 64'd3);

        // backpressure with input pending
        send_rand(1'b1, 1'b0);
        repeat (5) send_rand(1'b0, 1'b0);
        repeat (6) send_rand(1'b1, 1'b0);
        idle(1'b1);

        // wrap and start
        step(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b1, 1'b1, 32'd0, 1'b0);
        repeat (5) send_rand(1'b1, 1'b0);
        idle(1'b1);
        send_rand(1'b1, 1'b0);
        send_rand(1'b1, 1'b1);
        send_rand(1'b1, 1'b0);
        idle(1'b1);

        // random traffic with random backpressure and starts
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1'($urandom_range(0, 1)));
            else send_rand(1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
        end

        // async reset while a word is held
        send_rand(1'b1, 1'b0);
        send_rand(1'b0, 1'b0);
        step(1'b1, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0, 1'b0, NOP, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {63'd0, out_valid}, 64'd0);
        check("async_rst_errcnt", {56'd0, err_count}, 64'd0);
        check("async_rst_busy", {63'd0, busy}, 64'd0);
        exp_q.delete();
        addr_m = '0;
        err_m  = 8'd0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 7'b0110011, 5'd5, 5'd6, 5'd7, 3'd0, 7'b0100000, 32'hDEAD_BEEF, 1'b1, 1'b0,
             32'h4073_02B3, 1'b0);
        idle(1'b1);
        idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
